// File: rtl/pla_tt_sweeper.sv
// Exhaustive stimulus/capture wrapper for a combinational PLA netlist.
// Walks x_out through every input vector, samples y_in once per vector and
// compacts the responses into a MISR signature plus a ones-count, so an
// optimized netlist can be compared against a golden signature.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | no sweep active; results of an aborted sweep may be held
// S_RUN  | sweep in progress, one vector every SETTLE cycles
// S_DONE | all vectors sampled; signature/ones_count frozen, done high
module pla_tt_sweeper #(
  parameter int                 N_IN   = 10,
  parameter int                 SETTLE = 1,
  parameter int                 SIG_W  = 16,
  parameter logic [SIG_W-1:0]   POLY   = 16'h1021,
  parameter logic [SIG_W-1:0]   SEED   = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [N_IN-1:0]   x_out,
  input  logic              y_in,
  input  logic [SIG_W-1:0]  golden_sig,
  output logic              busy,
  output logic              done,
  output logic [SIG_W-1:0]  signature,
  output logic [N_IN:0]     ones_count,
  output logic              match
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // SETTLE is limited to 1..15, so a 4-bit counter covers the hold window
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t            state_q, state_d;
  logic [N_IN-1:0]   x_q, x_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [SIG_W-1:0]  sig_q, sig_d;
  logic [N_IN:0]     ones_q, ones_d;
  logic [3:0]        settle_q, settle_d;

  // Next-state and result update; abort outranks the sample edge in RUN
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    busy_d   = busy_q;
    done_d   = done_q;
    sig_d    = sig_q;
    ones_d   = ones_q;
    settle_d = settle_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_RUN;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          x_d      = '0;
          sig_d    = SEED;
          ones_d   = '0;
          settle_d = '0;
        end else if (abort) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d  = S_IDLE;
          busy_d   = 1'b0;
          done_d   = 1'b0;
          x_d      = '0;
          settle_d = '0;
        end else if (settle_q != SETTLE_LAST) begin
          settle_d = settle_q + 4'd1;
        end else begin
          sig_d    = {sig_q[SIG_W-2:0], 1'b0}
                   ^ (sig_q[SIG_W-1] ? POLY : '0)
                   ^ {{(SIG_W-1){1'b0}}, y_in};
          ones_d   = ones_q + {{N_IN{1'b0}}, y_in};
          settle_d = '0;
          if (x_q == '1) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      default: begin
        state_d  = S_IDLE;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        x_d      = '0;
        settle_d = '0;
      end
    endcase
  end

  // State and result registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sig_q    <= SEED;
      ones_q   <= '0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sig_q    <= sig_d;
      ones_q   <= ones_d;
      settle_q <= settle_d;
    end
  end

  assign x_out      = x_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign signature  = sig_q;
  assign ones_count = ones_q;
  assign match      = done_q && (sig_q == golden_sig);

endmodule

// File: doc/pla_tt_sweeper.md
Name: pla_tt_sweeper

Overview:
- Stimulus-and-capture stage wrapped around a 10-input, 1-output combinational PLA netlist in the autosymmetry benchmark flow.
- Drives every input vector (x0..x9) exhaustively and samples the netlist output y0.
- Compacts the responses into a MISR signature and a ones-count.
- Allows checking an optimized netlist against the original's golden signature in simulation or on silicon, without storing the 1024-entry truth table.

Parameters:
- N_IN, 10, number of netlist inputs; sweep length is 2^N_IN vectors.
- SETTLE, 1, cycles each vector is held before y0 is sampled; legal range 1..15.
- SIG_W, 16, MISR width.
- POLY, 16'h1021, MISR feedback polynomial, taps XORed when the MSB shifts out.
- SEED, 16'hFFFF, MISR value loaded at start.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE or DONE.
- abort  input  1  synchronous cancel of a running sweep.
- x_out  output  N_IN  vector driven to netlist inputs; bit i drives xi.
- y_in  input  1  netlist output y0 (combinational from x_out).
- golden_sig  input  SIG_W  expected signature, quasi-static.
- busy  output  1  high while the sweep runs.
- done  output  1  high from sweep completion until the next start or abort.
- signature  output  SIG_W  MISR state.
- ones_count  output  N_IN+1  number of vectors with y_in=1.
- match  output  1  done && (signature == golden_sig).

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, x_out=0, busy=0, done=0, signature=SEED, ones_count=0, settle counter=0.
- States: IDLE, RUN, DONE.
- IDLE/DONE, start=1 at edge E:
  - next state RUN; busy=1, done=0.
  - x_out=0, signature=SEED, ones_count=0, settle counter=0.
- RUN, per edge:
  - If the settle counter < SETTLE-1, increment it.
  - Otherwise (sample edge):
    - sample y_in;
    - signature <= {signature[SIG_W-2:0],1'b0} ^ (signature[SIG_W-1] ? POLY : 0) ^ y_in (XOR into bit 0);
    - ones_count += y_in;
    - settle counter=0.
  - On a sample edge, if x_out != all-ones: x_out increments.
  - On a sample edge, if x_out == all-ones: state=DONE, busy=0, done=1, x_out holds all-ones.
- Timing:
  - Vector v is driven from edge E+v*SETTLE and sampled at edge E+(v+1)*SETTLE.
  - done rises after edge E+2^N_IN*SETTLE (1024 cycles for the defaults).
  - Exactly 2^N_IN samples are taken; x_out never wraps within a sweep.
- DONE: all outputs hold; signature, ones_count and match stay stable until the next start.
- start while RUN: ignored, with no restart and no counter disturbance.
- abort:
  - In RUN (takes priority over the sample edge): state=IDLE, busy=0, done=0, x_out=0. Partial signature and ones_count are retained, and match=0.
  - In IDLE/DONE: done cleared, no other effect.
- start and abort in the same cycle:
  - In RUN: abort wins.
  - In IDLE/DONE: start wins and the sweep begins.
- rst_n asserted mid-sweep: immediate return to reset values; no partial results are retained.
- ones_count range 0..2^N_IN; the width N_IN+1 cannot overflow.
- match is combinational from registered signature, golden_sig and done.
- Any y_in glitches before a sample edge are ignored.

Test Plan:
- y_in tied to x_out[0], SETTLE=1, start pulse -> busy for exactly 1024 cycles; done rises 1024 edges after start; ones_count=512; signature equals the bench's bit-serial MISR model.
- y_in = AND of all x_out bits -> ones_count=1, single 1 sampled on the last sample edge; done=1; x_out=10'h3FF held.
- Netlist from the PLA benchmark (original, then optimized) connected; golden_sig taken from the original's run -> match=1 for the optimized netlist; flipping one y_in sample via a bench force -> match=0.
- SETTLE=3 -> x_out changes every 3 cycles; done after 3072 cycles; signature identical to the SETTLE=1 run for the same function.
- abort at cycle 300 of a run -> next edge busy=0, done=0, x_out=0, match=0; start during RUN at cycle 100 -> no effect, done still at cycle 1024.
- rst_n pulsed low mid-sweep (asynchronous, between edges) -> outputs immediately at reset values (signature=16'hFFFF, ones_count=0); a new start after release completes normally.
